wb_banked_ram: RTL and testbench

WB_BANKED_RAM -- requirements
Module: wb_banked_ram

---
 rtl/wb_banked_ram.sv | 135 +++++++++++++
 tb/tb_wb_banked_ram.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_banked_ram.sv
// Dual-port Wishbone front end over NUM_BANKS single-port RAM banks.
// Same-bank collisions are arbitrated by a per-bank toggling priority bit.
module wb_banked_ram #(
  parameter int NUM_BANKS  = 4,
  parameter int BANK_WORDS = 256,
  parameter int DATA_W     = 32,
  parameter int CNT_W      = 16,
  localparam int SEL_W     = DATA_W / 8,
  localparam int BB        = $clog2(NUM_BANKS),
  localparam int WB        = $clog2(BANK_WORDS),
  localparam int AW        = BB + WB
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              pA_wb_cyc_i,
  input  logic              pA_wb_stb_i,
  input  logic [SEL_W-1:0]  pA_wb_we_i,
  input  logic [AW-1:0]     pA_wb_addr_i,
  input  logic [DATA_W-1:0] pA_wb_data_i,
  output logic              pA_wb_ack_o,
  output logic              pA_wb_stall_o,
  output logic [DATA_W-1:0] pA_wb_data_o,
  input  logic              pB_wb_cyc_i,
  input  logic              pB_wb_stb_i,
  input  logic [SEL_W-1:0]  pB_wb_we_i,
  input  logic [AW-1:0]     pB_wb_addr_i,
  input  logic [DATA_W-1:0] pB_wb_data_i,
  output logic              pB_wb_ack_o,
  output logic              pB_wb_stall_o,
  output logic [DATA_W-1:0] pB_wb_data_o,
  input  logic              coll_clr_i,
  output logic [CNT_W-1:0]  coll_cnt_o
);

  // Handshake: a request is offered while cyc&stb are high and is taken on a
  // clock edge where stall is low; the matching ack follows exactly one cycle
  // later. A stalled request may be held or withdrawn by dropping cyc or stb.
  logic              aValid, bValid, aRead, bRead;
  logic [BB-1:0]     aBank, bBank, aBankQ, bBankQ;
  logic [WB-1:0]     aWord, bWord;
  logic              collision, aGrant, bGrant;
  logic [NUM_BANKS-1:0] prio;
  logic              aAck, bAck, aRdQ, bRdQ;
  logic [CNT_W-1:0]  collCnt;

  logic [NUM_BANKS-1:0] bankEn;
  logic [SEL_W-1:0]     bankWe    [NUM_BANKS];
  logic [WB-1:0]        bankWord  [NUM_BANKS];
  logic [DATA_W-1:0]    bankWData [NUM_BANKS];
  logic [DATA_W-1:0]    rdData    [NUM_BANKS];

  assign aValid = pA_wb_cyc_i && pA_wb_stb_i;
  assign bValid = pB_wb_cyc_i && pB_wb_stb_i;
  assign aRead  = (pA_wb_we_i == '0);
  assign bRead  = (pB_wb_we_i == '0);
  assign aBank  = pA_wb_addr_i[AW-1:WB];
  assign bBank  = pB_wb_addr_i[AW-1:WB];
  assign aWord  = pA_wb_addr_i[WB-1:0];
  assign bWord  = pB_wb_addr_i[WB-1:0];

  assign collision = aValid && bValid && (aBank == bBank);
  assign aGrant    = aValid && !(collision && prio[aBank]);
  assign bGrant    = bValid && !(collision && !prio[bBank]);

  assign pA_wb_stall_o = aValid && !aGrant;
  assign pB_wb_stall_o = bValid && !bGrant;

  // Route at most one granted request to each bank.
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      bankEn[b]    = 1'b0;
      bankWe[b]    = '0;
      bankWord[b]  = aWord;
      bankWData[b] = pA_wb_data_i;
      if (aGrant && (aBank == BB'(b))) begin
        bankEn[b]    = 1'b1;
        bankWe[b]    = pA_wb_we_i;
        bankWord[b]  = aWord;
        bankWData[b] = pA_wb_data_i;
      end else if (bGrant && (bBank == BB'(b))) begin
        bankEn[b]    = 1'b1;
        bankWe[b]    = pB_wb_we_i;
        bankWord[b]  = bWord;
        bankWData[b] = pB_wb_data_i;
      end
    end
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : gBank
    logic [DATA_W-1:0] mem [BANK_WORDS];
    logic [DATA_W-1:0] bankQ;

    always_ff @(posedge clk_i) begin
      if (bankEn[g]) begin
        if (bankWe[g] == '0) bankQ <= mem[bankWord[g]];
        for (int i = 0; i < SEL_W; i++) begin
          if (bankWe[g][i]) mem[bankWord[g]][i*8 +: 8] <= bankWData[g][i*8 +: 8];
        end
      end
    end

    assign rdData[g] = bankQ;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      aAck    <= 1'b0;
      bAck    <= 1'b0;
      aRdQ    <= 1'b0;
      bRdQ    <= 1'b0;
      aBankQ  <= '0;
      bBankQ  <= '0;
      prio    <= '0;
      collCnt <= '0;
    end else begin
      aAck   <= aGrant;
      bAck   <= bGrant;
      aRdQ   <= aGrant && aRead;
      bRdQ   <= bGrant && bRead;
      aBankQ <= aBank;
      bBankQ <= bBank;
      if (collision) prio[aBank] <= ~prio[aBank];
      if (coll_clr_i) collCnt <= '0;
      else if (collision && (collCnt != '1)) collCnt <= collCnt + CNT_W'(1);
    end
  end

  // Read data is gated by the registered read flag so write acks return zero.
  assign pA_wb_ack_o  = aAck;
  assign pB_wb_ack_o  = bAck;
  assign pA_wb_data_o = aRdQ ? rdData[aBankQ] : '0;
  assign pB_wb_data_o = bRdQ ? rdData[bBankQ] : '0;
  assign coll_cnt_o   = collCnt;

endmodule

// File: tb/tb_wb_banked_ram.sv
// Bench for wb_banked_ram: vector table with a per-port ack scoreboard,
// followed by a counter-saturation and mid-cycle reset sequence.
module tb_wb_banked_ram;

  logic        clk, rst;
  logic        pA_wb_cyc_i, pA_wb_stb_i, pB_wb_cyc_i, pB_wb_stb_i;
  logic [3:0]  pA_wb_we_i, pB_wb_we_i;
  logic [9:0]  pA_wb_addr_i, pB_wb_addr_i;
  logic [31:0] pA_wb_data_i, pB_wb_data_i;
  logic        pA_wb_ack_o, pA_wb_stall_o, pB_wb_ack_o, pB_wb_stall_o;
  logic [31:0] pA_wb_data_o, pB_wb_data_o;
  logic        coll_clr_i;
  logic [15:0] coll_cnt_o;

  wb_banked_ram dut (
    .clk_i(clk), .rst_i(rst),
    .pA_wb_cyc_i(pA_wb_cyc_i), .pA_wb_stb_i(pA_wb_stb_i), .pA_wb_we_i(pA_wb_we_i),
    .pA_wb_addr_i(pA_wb_addr_i), .pA_wb_data_i(pA_wb_data_i), .pA_wb_ack_o(pA_wb_ack_o),
    .pA_wb_stall_o(pA_wb_stall_o), .pA_wb_data_o(pA_wb_data_o),
    .pB_wb_cyc_i(pB_wb_cyc_i), .pB_wb_stb_i(pB_wb_stb_i), .pB_wb_we_i(pB_wb_we_i),
    .pB_wb_addr_i(pB_wb_addr_i), .pB_wb_data_i(pB_wb_data_i), .pB_wb_ack_o(pB_wb_ack_o),
    .pB_wb_stall_o(pB_wb_stall_o), .pB_wb_data_o(pB_wb_data_o),
    .coll_clr_i(coll_clr_i), .coll_cnt_o(coll_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic [3:0]  we;
    logic [9:0]  addr;
    logic [31:0] data;
  } req_t;

  typedef struct {
    req_t        a;
    req_t        b;
    logic        clr;
    logic        rstB;
    logic        aSt;
    logic        bSt;
    logic [15:0] cnt;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [31:0] expQA[$];
  logic [31:0] expQB[$];
  logic [31:0] model [1024];
  logic [15:0] expCnt;
  vec_t vecs [36];

  function automatic req_t rd(input logic [9:0] ad);
    return '{1'b1, 1'b1, 4'h0, ad, 32'h0};
  endfunction
  function automatic req_t wr(input logic [3:0] we, input logic [9:0] ad, input logic [31:0] d);
    return '{1'b1, 1'b1, we, ad, d};
  endfunction
  function automatic req_t idl();
    return '0;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic driveIdle();
    pA_wb_cyc_i = 0; pA_wb_stb_i = 0; pA_wb_we_i = 0; pA_wb_addr_i = 0; pA_wb_data_i = 0;
    pB_wb_cyc_i = 0; pB_wb_stb_i = 0; pB_wb_we_i = 0; pB_wb_addr_i = 0; pB_wb_data_i = 0;
    coll_clr_i = 0;
  endtask

  task automatic checkAcks(input int idx);
    logic [31:0] e;
    if (expQA.size() > 0) begin
      e = expQA.pop_front();
      chk($sformatf("ackA[%0d]", idx), pA_wb_ack_o, 1);
      chk($sformatf("dataA[%0d]", idx), pA_wb_data_o, e);
    end else begin
      chk($sformatf("noAckA[%0d]", idx), {pA_wb_ack_o, pA_wb_data_o}, 0);
    end
    if (expQB.size() > 0) begin
      e = expQB.pop_front();
      chk($sformatf("ackB[%0d]", idx), pB_wb_ack_o, 1);
      chk($sformatf("dataB[%0d]", idx), pB_wb_data_o, e);
    end else begin
      chk($sformatf("noAckB[%0d]", idx), {pB_wb_ack_o, pB_wb_data_o}, 0);
    end
    chk($sformatf("cnt[%0d]", idx), coll_cnt_o, expCnt);
  endtask

  task automatic accept(input req_t r, input bit portB);
    logic [31:0] e;
    e = 32'h0;
    if (r.we == 4'h0) e = model[r.addr];
    else for (int i = 0; i < 4; i++) if (r.we[i]) model[r.addr][i*8 +: 8] = r.data[i*8 +: 8];
    if (portB) expQB.push_back(e);
    else expQA.push_back(e);
  endtask

  task automatic doReset();
    @(negedge clk);
    checkAcks(-1);
    driveIdle();
    rst = 1'b1;
    #1;
    chk("rstAcks", {pA_wb_ack_o, pB_wb_ack_o}, 0);
    chk("rstData", {pA_wb_data_o, pB_wb_data_o}, 0);
    chk("rstCnt", coll_cnt_o, 0);
    @(negedge clk);
    rst = 1'b0;
    expQA.delete();
    expQB.delete();
    expCnt = 16'd0;
  endtask

  task automatic applyVec(input vec_t v, input int idx);
    if (v.rstB) doReset();
    @(negedge clk);
    checkAcks(idx);
    pA_wb_cyc_i = v.a.cyc; pA_wb_stb_i = v.a.stb; pA_wb_we_i = v.a.we;
    pA_wb_addr_i = v.a.addr; pA_wb_data_i = v.a.data;
    pB_wb_cyc_i = v.b.cyc; pB_wb_stb_i = v.b.stb; pB_wb_we_i = v.b.we;
    pB_wb_addr_i = v.b.addr; pB_wb_data_i = v.b.data;
    coll_clr_i = v.clr;
    #1;
    chk($sformatf("stallA[%0d]", idx), pA_wb_stall_o, v.aSt);
    chk($sformatf("stallB[%0d]", idx), pB_wb_stall_o, v.bSt);
    if (v.a.cyc && v.a.stb && !v.aSt) accept(v.a, 1'b0);
    if (v.b.cyc && v.b.stb && !v.bSt) accept(v.b, 1'b1);
    expCnt = v.cnt;
  endtask

  initial begin
    // Fields: A req, B req, clr, reset-before, A stall, B stall, count after edge.
    vecs[0]  = '{wr(4'hF, 10'h000, 32'hDEADBEEF), idl(), 0, 0, 0, 0, 16'd0};
    vecs[1]  = '{idl(), rd(10'h000), 0, 0, 0, 0, 16'd0};
    vecs[2]  = '{wr(4'hF, 10'h105, 32'h0105A5A5), wr(4'hF, 10'h310, 32'h33333333), 0, 0, 0, 0, 16'd0};
    vecs[3]  = '{wr(4'hF, 10'h010, 32'h00100010), wr(4'hF, 10'h1AA, 32'h1AA01AA0), 0, 0, 0, 0, 16'd0};
    vecs[4]  = '{'{1'b0, 1'b1, 4'hF, 10'h000, 32'hFFFFFFFF}, idl(), 0, 0, 0, 0, 16'd0};
    vecs[5]  = '{rd(10'h010), wr(4'hF, 10'h310, 32'h31003100), 0, 0, 0, 0, 16'd0};
    vecs[6]  = '{rd(10'h000), rd(10'h310), 0, 0, 0, 0, 16'd0};
    vecs[7]  = '{wr(4'hF, 10'h020, 32'h11223344), idl(), 0, 0, 0, 0, 16'd0};
    vecs[8]  = '{wr(4'b0010, 10'h020, 32'hAABBCCDD), idl(), 0, 0, 0, 0, 16'd0};
    vecs[9]  = '{rd(10'h020), idl(), 0, 0, 0, 0, 16'd0};
    vecs[10] = '{idl(), idl(), 0, 0, 0, 0, 16'd0};
    vecs[11] = '{rd(10'h105), rd(10'h1AA), 0, 1, 0, 1, 16'd1};
    vecs[12] = '{idl(), rd(10'h1AA), 0, 0, 0, 0, 16'd1};
    vecs[13] = '{idl(), idl(), 0, 0, 0, 0, 16'd1};
    vecs[14] = '{wr(4'hF, 10'h2A0, 32'hA0000001), wr(4'hF, 10'h2B0, 32'hB0000001), 0, 1, 0, 1, 16'd1};
    vecs[15] = '{wr(4'hF, 10'h2A0, 32'hA0000002), wr(4'hF, 10'h2B0, 32'hB0000001), 0, 0, 1, 0, 16'd2};
    vecs[16] = '{wr(4'hF, 10'h2A0, 32'hA0000002), wr(4'hF, 10'h2B0, 32'hB0000002), 0, 0, 0, 1, 16'd3};
    vecs[17] = '{wr(4'hF, 10'h2A0, 32'hA0000003), wr(4'hF, 10'h2B0, 32'hB0000002), 0, 0, 1, 0, 16'd4};
    vecs[18] = '{wr(4'hF, 10'h2A0, 32'hA0000003), idl(), 0, 0, 0, 0, 16'd4};
    vecs[19] = '{rd(10'h2A0), rd(10'h1AA), 0, 0, 0, 0, 16'd4};
    vecs[20] = '{idl(), rd(10'h2B0), 0, 0, 0, 0, 16'd4};
    vecs[21] = '{rd(10'h000), rd(10'h010), 0, 0, 0, 1, 16'd5};
    vecs[22] = '{idl(), rd(10'h010), 0, 0, 0, 0, 16'd5};
    vecs[23] = '{wr(4'hF, 10'h300, 32'h30003000), wr(4'hF, 10'h301, 32'h30103010), 0, 0, 0, 1, 16'd6};
    vecs[24] = '{idl(), wr(4'hF, 10'h301, 32'h30103010), 0, 0, 0, 0, 16'd6};
    vecs[25] = '{rd(10'h105), rd(10'h1AA), 0, 0, 0, 1, 16'd7};
    vecs[26] = '{idl(), rd(10'h1AA), 0, 0, 0, 0, 16'd7};
    vecs[27] = '{wr(4'hF, 10'h310, 32'hBADBAD00), rd(10'h300), 0, 0, 1, 0, 16'd8};
    vecs[28] = '{idl(), idl(), 0, 0, 0, 0, 16'd8};
    vecs[29] = '{rd(10'h310), rd(10'h301), 0, 0, 0, 1, 16'd9};
    vecs[30] = '{idl(), rd(10'h301), 0, 0, 0, 0, 16'd9};
    vecs[31] = '{rd(10'h000), rd(10'h010), 1, 0, 1, 0, 16'd0};
    vecs[32] = '{rd(10'h000), idl(), 0, 0, 0, 0, 16'd0};
    vecs[33] = '{rd(10'h000), rd(10'h010), 0, 0, 0, 1, 16'd1};
    vecs[34] = '{idl(), rd(10'h010), 0, 0, 0, 0, 16'd1};
    vecs[35] = '{idl(), idl(), 0, 0, 0, 0, 16'd1};

    driveIdle();
    rst = 1'b1;
    expCnt = 16'd0;
    repeat (3) @(negedge clk);
    chk("resetAcks", {pA_wb_ack_o, pB_wb_ack_o}, 0);
    chk("resetData", {pA_wb_data_o, pB_wb_data_o}, 0);
    chk("resetCnt", coll_cnt_o, 0);
    chk("resetStall", {pA_wb_stall_o, pB_wb_stall_o}, 0);
    rst = 1'b0;

    for (int i = 0; i < 36; i++) applyVec(vecs[i], i);
    @(negedge clk);
    checkAcks(36);

    // Saturate the collision counter with a continuous bank-0 collision.
    doReset();
    @(negedge clk);
    pA_wb_cyc_i = 1; pA_wb_stb_i = 1; pA_wb_we_i = 0; pA_wb_addr_i = 10'h000;
    pB_wb_cyc_i = 1; pB_wb_stb_i = 1; pB_wb_we_i = 0; pB_wb_addr_i = 10'h010;
    repeat (65535) @(posedge clk);
    @(negedge clk);
    chk("satReach", coll_cnt_o, 16'hFFFF);
    @(posedge clk);
    @(negedge clk);
    chk("satHold", coll_cnt_o, 16'hFFFF);
    chk("satOneAck", pA_wb_ack_o ^ pB_wb_ack_o, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("midRstAck", {pA_wb_ack_o, pB_wb_ack_o}, 0);
    chk("midRstData", {pA_wb_data_o, pB_wb_data_o}, 0);
    chk("midRstCnt", coll_cnt_o, 0);
    driveIdle();
    @(posedge clk);
    #1;
    chk("rstEdgeAck", {pA_wb_ack_o, pB_wb_ack_o}, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("postRstAck[%0d]", i), {pA_wb_ack_o, pB_wb_ack_o}, 0);
      chk($sformatf("postRstCnt[%0d]", i), coll_cnt_o, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
